// File: rtl/itype_block_sequencer_if.sv
// rtl/itype_block_sequencer_if.sv - commit-lane inputs and closed-block output bundle
// master drives the commit lanes and blk_ready_i; slave is the sequencer.
interface itype_block_sequencer_if #(
  parameter int unsigned NRET        = 2,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ITYPE_LEN   = 4,
  parameter int unsigned IRETIRE_LEN = 8
);
  logic [NRET-1:0]                valid_i;
  logic [NRET-1:0][ITYPE_LEN-1:0] itype_i;
  logic [NRET-1:0][XLEN-1:0]      iaddr_i;
  logic [NRET-1:0]                compressed_i;
  logic                           blk_valid_o;
  logic                           blk_ready_i;
  logic [ITYPE_LEN-1:0]           blk_itype_o;
  logic [XLEN-1:0]                blk_iaddr_o;
  logic [IRETIRE_LEN-1:0]         blk_iretire_o;
  logic                           blk_ilastsize_o;
  logic                           overflow_o;

  modport master (
    output valid_i, itype_i, iaddr_i, compressed_i, blk_ready_i,
    input  blk_valid_o, blk_itype_o, blk_iaddr_o, blk_iretire_o, blk_ilastsize_o, overflow_o
  );

  modport slave (
    input  valid_i, itype_i, iaddr_i, compressed_i, blk_ready_i,
    output blk_valid_o, blk_itype_o, blk_iaddr_o, blk_iretire_o, blk_ilastsize_o, overflow_o
  );
endinterface

// File: rtl/itype_block_sequencer.sv
// rtl/itype_block_sequencer.sv - merges retired instructions into blocks for the trace encoder
// Lanes are folded oldest-first into one open block; closed blocks queue in a small FIFO.
module itype_block_sequencer #(
  parameter int unsigned NRET        = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ITYPE_LEN   = 4,
  parameter int unsigned IRETIRE_LEN = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  itype_block_sequencer_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [IRETIRE_LEN-1:0] SAT_LIMIT = IRETIRE_LEN'((1 << IRETIRE_LEN) - 3);
  localparam logic [IRETIRE_LEN-1:0] ONE_HW    = IRETIRE_LEN'(1);
  localparam logic [IRETIRE_LEN-1:0] TWO_HW    = IRETIRE_LEN'(2);
  localparam logic [CW-1:0]          DEPTH_C   = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
  } blk_t;

  blk_t                   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]          count_q;

  // A zero count doubles as the "open block empty" flag.
  logic [XLEN-1:0]        start_q, start_d;
  logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
  logic                   last_q, last_d;

  blk_t                   push_blk [NRET];
  logic [AW-1:0]          push_off [NRET];
  logic [NRET-1:0]        push_en;
  logic [CW-1:0]          free_slots, n_acc;
  logic                   blk_valid, pop, overflow;

  assign blk_valid = (count_q != '0);
  assign pop       = blk_valid & bus.blk_ready_i;

  always_comb begin
    start_d    = start_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    push_en    = '0;
    n_acc      = '0;
    overflow   = 1'b0;
    free_slots = DEPTH_C - count_q + CW'(pop);
    for (int i = 0; i < NRET; i++) begin
      push_blk[i] = '0;
      push_off[i] = '0;
      if (bus.valid_i[i]) begin
        if (cnt_d == '0) begin
          start_d = bus.iaddr_i[i];
        end
        cnt_d  = cnt_d + (bus.compressed_i[i] ? ONE_HW : TWO_HW);
        last_d = ~bus.compressed_i[i];
        if ((bus.itype_i[i] != '0) || (cnt_d > SAT_LIMIT)) begin
          push_blk[i].itype     = bus.itype_i[i];
          push_blk[i].iaddr     = start_d;
          push_blk[i].iretire   = cnt_d;
          push_blk[i].ilastsize = last_d;
          // Older closes claim free slots first, so drops hit the youngest.
          if (n_acc < free_slots) begin
            push_en[i]  = 1'b1;
            push_off[i] = n_acc[AW-1:0];
            n_acc       = n_acc + CW'(1);
          end else begin
            overflow = 1'b1;
          end
          cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      for (int i = 0; i < NRET; i++) begin
        if (push_en[i]) begin
          mem_q[wr_ptr_q + push_off[i]] <= push_blk[i];
        end
      end
      wr_ptr_q <= wr_ptr_q + n_acc[AW-1:0];
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q + n_acc - CW'(pop);
    end
  end

  assign bus.blk_valid_o     = blk_valid;
  assign bus.blk_itype_o     = mem_q[rd_ptr_q].itype;
  assign bus.blk_iaddr_o     = mem_q[rd_ptr_q].iaddr;
  assign bus.blk_iretire_o   = mem_q[rd_ptr_q].iretire;
  assign bus.blk_ilastsize_o = mem_q[rd_ptr_q].ilastsize;
  assign bus.overflow_o      = overflow;
endmodule

// File: tb/tb_itype_block_sequencer.sv
// tb/tb_itype_block_sequencer.sv - directed bench with a queue-based block model
// The model folds lanes into blocks with plain integers and keeps a queue of expected FIFO entries.
module tb_itype_block_sequencer;
  localparam int NRET = 2;
  localparam int DEPTH = 4;
  localparam int XLEN = 64;
  localparam int ITL = 4;
  localparam int IRL = 8;
  localparam int SAT = (1 << IRL) - 3;

  typedef struct {
    logic [3:0]  itype;
    logic [63:0] iaddr;
    int          iretire;
    logic        last;
  } blk_t;

  logic clk;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovf_cnt = 0;

  blk_t m_q[$];
  blk_t acc_q[$];
  blk_t closed[$];
  logic [63:0] m_start;
  int          m_cnt;
  logic        m_last;

  itype_block_sequencer_if #(.NRET(NRET), .XLEN(XLEN), .ITYPE_LEN(ITL), .IRETIRE_LEN(IRL)) bus ();

  itype_block_sequencer #(
    .NRET(NRET), .FIFO_DEPTH(DEPTH), .XLEN(XLEN), .ITYPE_LEN(ITL), .IRETIRE_LEN(IRL)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input int idx, input logic [3:0] it,
                           input logic [63:0] a, input int ir, input logic l);
    if (idx < acc_q.size()) begin
      check($sformatf("%s.itype", name), 64'(acc_q[idx].itype), 64'(it));
      check($sformatf("%s.iaddr", name), acc_q[idx].iaddr, a);
      check($sformatf("%s.iretire", name), 64'(acc_q[idx].iretire), 64'(ir));
      check($sformatf("%s.ilastsize", name), 64'(acc_q[idx].last), 64'(l));
    end else begin
      check($sformatf("%s.present", name), 64'(acc_q.size()), 64'(idx + 1));
    end
  endtask

  // Model step and per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!rst_ni) begin
      m_q.delete();
      m_cnt = 0;
      check("rst_blk_valid", 64'(bus.blk_valid_o), 64'd0);
    end else begin
      logic exp_valid;
      logic exp_ovf;
      blk_t b;
      exp_valid = (m_q.size() != 0);
      check("blk_valid", 64'(bus.blk_valid_o), 64'(exp_valid));
      if (exp_valid) begin
        check("head_itype", 64'(bus.blk_itype_o), 64'(m_q[0].itype));
        check("head_iaddr", bus.blk_iaddr_o, m_q[0].iaddr);
        check("head_iretire", 64'(bus.blk_iretire_o), 64'(m_q[0].iretire));
        check("head_ilastsize", 64'(bus.blk_ilastsize_o), 64'(m_q[0].last));
      end
      closed.delete();
      for (int i = 0; i < NRET; i++) begin
        if (bus.valid_i[i]) begin
          if (m_cnt == 0) m_start = bus.iaddr_i[i];
          m_cnt  = m_cnt + (bus.compressed_i[i] ? 1 : 2);
          m_last = !bus.compressed_i[i];
          if (bus.itype_i[i] != 0 || m_cnt > SAT) begin
            b.itype = bus.itype_i[i];
            b.iaddr = m_start;
            b.iretire = m_cnt;
            b.last = m_last;
            closed.push_back(b);
            m_cnt = 0;
          end
        end
      end
      if (exp_valid && bus.blk_ready_i) begin
        b.itype = bus.blk_itype_o;
        b.iaddr = bus.blk_iaddr_o;
        b.iretire = int'(bus.blk_iretire_o);
        b.last = bus.blk_ilastsize_o;
        acc_q.push_back(b);
        void'(m_q.pop_front());
      end
      exp_ovf = 1'b0;
      foreach (closed[k]) begin
        if (m_q.size() < DEPTH) m_q.push_back(closed[k]);
        else exp_ovf = 1'b1;
      end
      check("overflow", 64'(bus.overflow_o), 64'(exp_ovf));
      if (bus.overflow_o) ovf_cnt++;
    end
  end

  task automatic drive(input logic v0, input logic [63:0] a0, input logic c0, input logic [3:0] t0,
                       input logic v1, input logic [63:0] a1, input logic c1, input logic [3:0] t1);
    bus.valid_i         = {v1, v0};
    bus.iaddr_i[0]      = a0;
    bus.iaddr_i[1]      = a1;
    bus.compressed_i    = {c1, c0};
    bus.itype_i[0]      = t0;
    bus.itype_i[1]      = t1;
    @(posedge clk);
    #1;
    bus.valid_i = '0;
  endtask

  task automatic one(input logic [63:0] a, input logic c, input logic [3:0] t);
    drive(1'b1, a, c, t, 1'b0, 64'd0, 1'b0, 4'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_ni           = 1'b0;
    bus.valid_i      = '0;
    bus.iaddr_i      = '0;
    bus.itype_i      = '0;
    bus.compressed_i = '0;
    bus.blk_ready_i  = 1'b0;
    idle(3);
    check("reset.blk_valid", 64'(bus.blk_valid_o), 64'd0);
    check("reset.iaddr", bus.blk_iaddr_o, 64'd0);
    check("reset.iretire", 64'(bus.blk_iretire_o), 64'd0);
    check("reset.itype", 64'(bus.blk_itype_o), 64'd0);
    check("reset.overflow", 64'(bus.overflow_o), 64'd0);
    rst_ni = 1'b1;
    idle(1);

    // Merge and close across two cycles.
    bus.blk_ready_i = 1'b1;
    one(64'h1000, 1'b0, 4'd0);
    drive(1'b1, 64'h1004, 1'b1, 4'd0, 1'b1, 64'h1006, 1'b0, 4'd4);
    check("merge.valid_next_cycle", 64'(bus.blk_valid_o), 64'd1);
    idle(3);
    check("merge.count", 64'(acc_q.size()), 64'd1);
    check_blk("merge", 0, 4'd4, 64'h1000, 5, 1'b1);

    // Two closes in one cycle.
    acc_q.delete();
    drive(1'b1, 64'h2000, 1'b0, 4'd2, 1'b1, 64'h3000, 1'b0, 4'd5);
    idle(4);
    check("two.count", 64'(acc_q.size()), 64'd2);
    check_blk("two0", 0, 4'd2, 64'h2000, 2, 1'b1);
    check_blk("two1", 1, 4'd5, 64'h3000, 2, 1'b1);

    // Counter saturation.
    acc_q.delete();
    for (int i = 0; i < 127; i++) one(64'h4000 + 64'(4 * i), 1'b0, 4'd0);
    idle(2);
    check("sat.count", 64'(acc_q.size()), 64'd1);
    check_blk("sat", 0, 4'd0, 64'h4000, 254, 1'b1);
    one(64'h41FC, 1'b0, 4'd0);
    one(64'h4200, 1'b1, 4'd1);
    idle(3);
    check_blk("sat_next", 1, 4'd1, 64'h41FC, 3, 1'b0);

    // Backpressure and overflow.
    acc_q.delete();
    ovf_cnt = 0;
    bus.blk_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) one(64'h5000 + 64'(16 * i), 1'b0, 4'd6);
    check("bp.ovf_pulses", 64'(ovf_cnt), 64'd1);
    check("bp.head_held", bus.blk_iaddr_o, 64'h5000);
    bus.blk_ready_i = 1'b1;
    idle(6);
    check("bp.drained", 64'(acc_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_blk($sformatf("bp%0d", i), i, 4'd6, 64'h5000 + 64'(16 * i), 2, 1'b1);

    // Pop and push in the same cycle while full.
    acc_q.delete();
    ovf_cnt = 0;
    bus.blk_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) one(64'h6000 + 64'(16 * i), 1'b0, 4'd6);
    bus.blk_ready_i = 1'b1;
    one(64'h6040, 1'b0, 4'd6);
    bus.blk_ready_i = 1'b0;
    check("full_pp.no_ovf", 64'(ovf_cnt), 64'd0);
    one(64'h6050, 1'b0, 4'd6);
    check("full_pp.still_full", 64'(ovf_cnt), 64'd1);
    bus.blk_ready_i = 1'b1;
    idle(6);
    check("full_pp.drained", 64'(acc_q.size()), 64'd5);
    check_blk("full_pp_first", 0, 4'd6, 64'h6000, 2, 1'b1);
    check_blk("full_pp_last", 4, 4'd6, 64'h6040, 2, 1'b1);

    // Reset in the middle of activity.
    acc_q.delete();
    bus.blk_ready_i = 1'b0;
    drive(1'b1, 64'h7000, 1'b0, 4'd1, 1'b1, 64'h7010, 1'b0, 4'd1);
    one(64'h8000, 1'b0, 4'd0);
    one(64'h8004, 1'b0, 4'd0);
    one(64'h8008, 1'b0, 4'd0);
    check("rst_mid.pre_valid", 64'(bus.blk_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid.async_valid", 64'(bus.blk_valid_o), 64'd0);
    idle(2);
    rst_ni = 1'b1;
    bus.blk_ready_i = 1'b1;
    drive(1'b1, 64'h9000, 1'b1, 4'd0, 1'b1, 64'h9002, 1'b0, 4'd7);
    idle(3);
    check("rst_mid.count", 64'(acc_q.size()), 64'd1);
    check_blk("rst_mid", 0, 4'd7, 64'h9000, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
